nebula_fifo_rd_adapter: RTL and testbench

- Read-side controller for a nebula_fifo instance.
- nebula_fifo has a registered read: rd_data is valid the cycle after an accepted rd_en.
- This block drains that read port and presents a valid/ready stream with a 2-entry output buffer, so full throughput is kept under backpressure.
- Provides enable, a flush (drain-and-discard) sequence, and a delivered-word counter; it sits between a router input FIFO and downstream switch/arbiter logic.

---
 rtl/nebula_fifo_rd_adapter.sv | 118 +++++++++++
 tb/tb_nebula_fifo_rd_adapter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nebula_fifo_rd_adapter.sv
// Read-side adapter for a nebula_fifo with registered read data.
// Drains the FIFO read port into a 2-entry output buffer and presents a
// valid/ready stream, with enable, flush (drain-and-discard) and a
// delivered-word counter.
module nebula_fifo_rd_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head_data;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  rd_en;
  logic                  pop;
  logic                  land;
  logic [2:0]            pending;

  assign m_valid    = (occ != 2'd0);
  assign m_data     = head_data;
  assign pop        = m_valid && m_ready;
  assign land       = inflight && (state == RUN);
  assign pending    = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = rd_en;
  assign busy       = (state == FLUSH) || (occ != 2'd0) || inflight;

  // Next-state, read issue and flush completion; reads are gated off during reset
  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        rd_en = en && !fifo_empty && ((pending < 3'd2) || pop);
        if (flush) state_nxt = FLUSH;
      end
      FLUSH: begin
        rd_en = !fifo_empty;
        if (fifo_empty && !inflight) begin
          flush_done = 1'b1;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (rst) rd_en = 1'b0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Buffer occupancy, in-flight tracking and FIFO-ordered landing/popping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= 2'd0;
      inflight  <= 1'b0;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      inflight <= rd_en;
      if (state == FLUSH || flush) begin
        occ <= 2'd0;
      end else begin
        case ({land, pop})
          2'b11: begin
            if (occ == 2'd2) begin
              head_data <= tail_data;
              tail_data <= fifo_rd_data;
            end else begin
              head_data <= fifo_rd_data;
            end
          end
          2'b10: begin
            if (occ == 2'd0) head_data <= fifo_rd_data;
            else             tail_data <= fifo_rd_data;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            head_data <= tail_data;
            occ       <= occ - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Delivered-word counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      xfer_count <= '0;
    else if (pop) xfer_count <= xfer_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_nebula_fifo_rd_adapter.sv
// Directed bench for nebula_fifo_rd_adapter with a behavioural FIFO model.
module tb_nebula_fifo_rd_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic        flush_done;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        busy;
  logic [3:0]  xfer_count;

  nebula_fifo_rd_adapter #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .flush_done(flush_done),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int rd_viol = 0;
  int underflow = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int win_valid = 0;
  int hold_chg = 0;
  int first_rd = -1;
  int first_v = -1;
  logic flush_win = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] fq[$];
  logic [31:0] rx[$];
  int rx_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // FIFO model: registered read, empty flag updated at the read edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
      else underflow++;
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Mid-cycle monitor
  always @(negedge clk) begin
    if (fifo_rd_en) rd_cnt++;
    if (fifo_rd_en && fifo_empty) rd_viol++;
    if (fifo_rd_en && first_rd < 0) first_rd = cyc;
    if (m_valid && first_v < 0) first_v = cyc;
    if (flush_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (flush_win && m_valid) win_valid++;
    if (m_valid && m_ready) begin
      rx.push_back(m_data);
      rx_cyc.push_back(cyc);
    end
    if (prev_stall && m_valid && m_data != prev_data) hold_chg++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
  end

  initial begin
    int rb;
    int db;
    int fc;
    rst = 1'b1; en = 1'b1; m_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(32'h100 + i);
    step(3);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", xfer_count, 0);
    chk("rst_done", flush_done, 0);
    rst = 1'b0;
    step(20);
    chk("t1_n", rx.size(), 8);
    for (int i = 0; i < 8 && i < rx.size(); i++) chk("t1_data", rx[i], 32'h100 + i);
    if (rx.size() == 8) chk("t1_consec", rx_cyc[7] - rx_cyc[0], 7);
    chk("t1_latency", first_v - first_rd, 2);
    chk("t1_cnt", xfer_count, 8);

    m_ready = 1'b0; rx.delete(); rb = rd_cnt;
    for (int i = 0; i < 4; i++) fq.push_back(32'h200 + i);
    step(10);
    chk("t2_reads", rd_cnt - rb, 2);
    chk("t2_valid", m_valid, 1);
    chk("t2_head", m_data, 32'h200);
    chk("t2_hold", hold_chg, 0);
    m_ready = 1'b1;
    step(10);
    chk("t2_n", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++) chk("t2_data", rx[i], 32'h200 + i);
    chk("t2_cnt", xfer_count, 12);

    rx.delete(); rb = rd_cnt;
    fq.push_back(32'h3A5);
    step(8);
    chk("t3_reads", rd_cnt - rb, 1);
    chk("t3_n", rx.size(), 1);
    if (rx.size() > 0) chk("t3_data", rx[0], 32'h3A5);
    chk("t3_cnt", xfer_count, 13);

    m_ready = 1'b0; rx.delete();
    for (int i = 0; i < 6; i++) fq.push_back(32'h300 + i);
    step(5);
    chk("t4_pre_valid", m_valid, 1);
    db = done_cnt;
    flush = 1'b1;
    step(1);
    flush = 1'b0; flush_win = 1'b1;
    step(20);
    flush_win = 1'b0;
    chk("t4_done", done_cnt - db, 1);
    chk("t4_valid", win_valid, 0);
    chk("t4_empty", fifo_empty, 1);
    chk("t4_fq", fq.size(), 0);
    chk("t4_busy", busy, 0);
    chk("t4_rx", rx.size(), 0);
    m_ready = 1'b1;
    fq.push_back(32'hCAFEBABE);
    step(6);
    chk("t4_n", rx.size(), 1);
    if (rx.size() > 0) chk("t4_data", rx[0], 32'hCAFEBABE);
    chk("t4_cnt", xfer_count, 14);

    db = done_cnt;
    flush = 1'b1; fc = cyc;
    step(1);
    flush = 1'b0;
    step(3);
    chk("fe_done", done_cnt - db, 1);
    chk("fe_cyc", done_cyc, fc + 1);

    en = 1'b0; rx.delete(); rb = rd_cnt;
    for (int i = 0; i < 3; i++) fq.push_back(32'h400 + i);
    step(8);
    chk("t5_reads", rd_cnt - rb, 0);
    chk("t5_valid", m_valid, 0);
    en = 1'b1;
    step(8);
    chk("t5_n", rx.size(), 3);
    for (int i = 0; i < 3 && i < rx.size(); i++) chk("t5_data", rx[i], 32'h400 + i);
    chk("t5_cnt", xfer_count, 1);

    rx.delete();
    for (int i = 0; i < 14; i++) fq.push_back(32'h500 + i);
    step(20);
    chk("t6_n", rx.size(), 14);
    chk("t6_cnt15", xfer_count, 15);
    fq.push_back(32'h5FF);
    step(6);
    chk("t6_wrap", xfer_count, 0);

    for (int i = 0; i < 6; i++) fq.push_back(32'h600 + i);
    step(3);
    chk("t7_pre_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("t7_valid", m_valid, 0);
    chk("t7_data", m_data, 0);
    chk("t7_rd_en", fifo_rd_en, 0);
    chk("t7_busy", busy, 0);
    chk("t7_cnt", xfer_count, 0);
    chk("t7_done", flush_done, 0);
    step(2);
    rst = 1'b0;
    step(20);
    chk("rd_while_empty", rd_viol, 0);
    chk("underflow", underflow, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
